// File: rtl/comparator_sort_controller_if.sv
// Valid/ready stream bundle for comparator_sort_controller: one input stream
// of 4-bit values and one output stream of the sorted values.
interface comparator_sort_controller_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/comparator_sort_controller.sv
// Bubble-sort sequencer for blocks of N 4-bit values. One shared
// four_bit_comparator decides every swap, one comparison per cycle.

module four_bit_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       g,
    output logic       e,
    output logic       l
);
    // Magnitude compare of two unsigned nibbles
    always_comb begin
        g = 1'b0;
        e = 1'b0;
        l = 1'b0;
        if (a > b) begin
            g = 1'b1;
        end else if (a == b) begin
            e = 1'b1;
        end else begin
            l = 1'b1;
        end
    end
endmodule

module comparator_sort_controller #(
    parameter int N    = 4,
    parameter int IDXW = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    comparator_sort_controller_if.slave    stream,
    output logic                           busy,
    output logic                           sort_done,
    output logic [7:0]                     swap_cnt
);
    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        SORT_CMP  = 2'd1,
        SORT_SWAP = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    localparam int DEPTH = 2 ** IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [IDXW-1:0] LAST_PASS = IDXW'(N - 2);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    state_t          state_r;
    logic [3:0]      mem_r [DEPTH];
    logic [IDXW-1:0] wr_idx_r;
    logic [IDXW-1:0] rd_idx_r;
    logic [IDXW-1:0] j_r;
    logic [IDXW-1:0] pass_r;
    logic            swapped_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [3:0]      out_data_r;
    logic            busy_r;
    logic            sort_done_r;
    logic [7:0]      swap_cnt_r;

    logic [IDXW-1:0] j_nxt_s;
    logic [IDXW-1:0] rd_nxt_s;
    logic [IDXW-1:0] last_j_s;
    logic [3:0]      cmp_a_s;
    logic [3:0]      cmp_b_s;
    logic            cmp_g_s;
    logic            cmp_e_unused_s;
    logic            cmp_l_unused_s;
    logic            swapped_eff_s;
    logic            pass_end_s;
    logic            go_drain_s;
    logic [3:0]      first_out_s;

    four_bit_comparator u_cmp (
        .a (cmp_a_s),
        .b (cmp_b_s),
        .g (cmp_g_s),
        .e (cmp_e_unused_s),
        .l (cmp_l_unused_s)
    );

    // Pair selection and end-of-pass / early-exit decisions
    always_comb begin
        j_nxt_s       = j_r + IDX_ONE;
        rd_nxt_s      = rd_idx_r + IDX_ONE;
        last_j_s      = LAST_PASS - pass_r;
        cmp_a_s       = mem_r[j_r];
        cmp_b_s       = mem_r[j_nxt_s];
        swapped_eff_s = swapped_r;
        first_out_s   = mem_r[0];
        if (state_r == SORT_SWAP) begin
            swapped_eff_s = 1'b1;
        end else begin
            swapped_eff_s = swapped_r;
        end
        pass_end_s = (j_r >= last_j_s);
        go_drain_s = pass_end_s && (!swapped_eff_s || (pass_r == LAST_PASS));
        // A swap at j=0 in the final cycle is not yet visible in mem_r[0]
        if ((state_r == SORT_SWAP) && (j_r == IDX_ZERO)) begin
            first_out_s = mem_r[1];
        end else begin
            first_out_s = mem_r[0];
        end
    end

    // Controller FSM with registered stream and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= LOAD;
            wr_idx_r    <= IDX_ZERO;
            rd_idx_r    <= IDX_ZERO;
            j_r         <= IDX_ZERO;
            pass_r      <= IDX_ZERO;
            swapped_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 4'd0;
            busy_r      <= 1'b0;
            sort_done_r <= 1'b0;
            swap_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    sort_done_r <= 1'b0;
                    if (stream.in_valid && in_ready_r) begin
                        mem_r[wr_idx_r] <= stream.in_data;
                        if (wr_idx_r == LAST_IDX) begin
                            state_r    <= SORT_CMP;
                            wr_idx_r   <= IDX_ZERO;
                            j_r        <= IDX_ZERO;
                            pass_r     <= IDX_ZERO;
                            swapped_r  <= 1'b0;
                            swap_cnt_r <= 8'd0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            wr_idx_r <= wr_idx_r + IDX_ONE;
                        end
                    end
                end
                SORT_CMP, SORT_SWAP: begin
                    if ((state_r == SORT_CMP) && cmp_g_s) begin
                        state_r <= SORT_SWAP;
                    end else begin
                        if (state_r == SORT_SWAP) begin
                            mem_r[j_r]     <= mem_r[j_nxt_s];
                            mem_r[j_nxt_s] <= mem_r[j_r];
                            swapped_r      <= 1'b1;
                            if (swap_cnt_r != 8'hFF) begin
                                swap_cnt_r <= swap_cnt_r + 8'd1;
                            end
                        end
                        if (!pass_end_s) begin
                            j_r     <= j_nxt_s;
                            state_r <= SORT_CMP;
                        end else if (go_drain_s) begin
                            state_r     <= DRAIN;
                            busy_r      <= 1'b0;
                            sort_done_r <= 1'b1;
                            out_valid_r <= 1'b1;
                            out_data_r  <= first_out_s;
                            rd_idx_r    <= IDX_ZERO;
                        end else begin
                            pass_r    <= pass_r + IDX_ONE;
                            j_r       <= IDX_ZERO;
                            swapped_r <= 1'b0;
                            state_r   <= SORT_CMP;
                        end
                    end
                end
                DRAIN: begin
                    sort_done_r <= 1'b0;
                    if (stream.out_ready) begin
                        if (rd_idx_r == LAST_IDX) begin
                            state_r     <= LOAD;
                            rd_idx_r    <= IDX_ZERO;
                            wr_idx_r    <= IDX_ZERO;
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                        end else begin
                            rd_idx_r   <= rd_nxt_s;
                            out_data_r <= mem_r[rd_nxt_s];
                        end
                    end
                end
                default: begin
                    state_r     <= LOAD;
                    wr_idx_r    <= IDX_ZERO;
                    rd_idx_r    <= IDX_ZERO;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    sort_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign stream.in_ready  = in_ready_r;
    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign busy             = busy_r;
    assign sort_done        = sort_done_r;
    assign swap_cnt         = swap_cnt_r;
endmodule

// File: tb/tb_comparator_sort_controller.sv
// Self-checking bench for comparator_sort_controller: directed blocks from
// the test plan plus randomized blocks against a counting/inversion model.
module tb_comparator_sort_controller;
    localparam int N    = 4;
    localparam int IDXW = 3;
    typedef logic [3:0] blk_t [N];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       sort_done;
    logic [7:0] swap_cnt;
    int         tests  = 0;
    int         failed = 0;

    comparator_sort_controller_if bus ();

    comparator_sort_controller #(.N(N), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stream    (bus),
        .busy      (busy),
        .sort_done (sort_done),
        .swap_cnt  (swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sorted order by counting, swaps = inversion count, passes from max left-displacement
    function automatic void model(input blk_t v, output blk_t s, output int swaps, output int busy_cyc);
        int cnt [16];
        int k;
        int disp;
        int passes;
        int idx;
        for (int x = 0; x < 16; x++) cnt[x] = 0;
        for (int i = 0; i < N; i++) cnt[v[i]]++;
        idx = 0;
        for (int x = 0; x < 16; x++) begin
            for (int c = 0; c < cnt[x]; c++) begin
                s[idx] = 4'(x);
                idx++;
            end
        end
        swaps = 0;
        k = 0;
        for (int j = 0; j < N; j++) begin
            disp = 0;
            for (int i = 0; i < j; i++) if (v[i] > v[j]) disp++;
            swaps += disp;
            if (disp > k) k = disp;
        end
        passes = (k + 1 < N - 1) ? k + 1 : N - 1;
        busy_cyc = swaps;
        for (int p = 0; p < passes; p++) busy_cyc += N - 1 - p;
    endfunction

    task automatic load_block(input blk_t v, input string tag);
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            check({tag, "/in_ready_load"}, 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // rmode: 0 = always ready, 1 = pattern 1,0,0,1, otherwise random
    task automatic sort_drain(input blk_t v, input int rmode, input bit noise, input string tag);
        blk_t s;
        int   swaps;
        int   bexp;
        int   bcnt;
        int   idx;
        int   cyc;
        logic r;
        model(v, s, swaps, bexp);
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 200) begin
            check({tag, "/in_ready_sort"}, 32'(bus.in_ready), 32'd0);
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 4'($urandom_range(0, 15));
            end
            bcnt++;
            step();
        end
        check({tag, "/busy_cycles"}, 32'(bcnt), 32'(bexp));
        check({tag, "/sort_done_pulse"}, 32'(sort_done), 32'd1);
        check({tag, "/swap_cnt"}, 32'(swap_cnt), 32'(swaps));
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 200) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = r;
            check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "/out_data"}, 32'(bus.out_data), 32'(s[idx]));
            check({tag, "/in_ready_drain"}, 32'(bus.in_ready), 32'd0);
            if (cyc > 0) check({tag, "/sort_done_low"}, 32'(sort_done), 32'd0);
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 4'($urandom_range(0, 15));
            end
            step();
            cyc++;
            if (r) idx++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "/drained"}, 32'(idx), 32'(N));
        check({tag, "/out_valid_after"}, 32'(bus.out_valid), 32'd0);
        check({tag, "/in_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "/swap_cnt_hold"}, 32'(swap_cnt), 32'(swaps));
    endtask

    initial begin
        blk_t v;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst/in_ready", 32'(bus.in_ready), 32'd1);
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/sort_done", 32'(sort_done), 32'd0);
        check("rst/swap_cnt", 32'(swap_cnt), 32'd0);
        rst_n = 1'b1;

        v = '{4'd15, 4'd9, 4'd4, 4'd0};
        load_block(v, "rev");
        sort_drain(v, 0, 1'b0, "rev");

        v = '{4'd1, 4'd2, 4'd3, 4'd4};
        load_block(v, "sorted");
        sort_drain(v, 0, 1'b0, "sorted");

        v = '{4'd7, 4'd7, 4'd3, 4'd7};
        load_block(v, "dups");
        sort_drain(v, 0, 1'b0, "dups");

        v = '{4'd5, 4'hA, 4'd2, 4'd8};
        load_block(v, "stall");
        sort_drain(v, 1, 1'b1, "stall");

        v = '{4'd15, 4'd9, 4'd4, 4'd0};
        load_block(v, "midrst");
        for (int i = 0; i < 3; i++) begin
            check("midrst/busy_before", 32'(busy), 32'd1);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst/in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst/swap_cnt", 32'(swap_cnt), 32'd0);
        v = '{4'd3, 4'd1, 4'd2, 4'd0};
        load_block(v, "fresh");
        sort_drain(v, 0, 1'b0, "fresh");

        v = '{4'd9, 4'd0, 4'd9, 4'd1};
        load_block(v, "b2b_a");
        sort_drain(v, 0, 1'b0, "b2b_a");
        v = '{4'd6, 4'd14, 4'd2, 4'd2};
        load_block(v, "b2b_b");
        sort_drain(v, 0, 1'b0, "b2b_b");

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) v[i] = 4'($urandom_range(0, 15));
            load_block(v, "rand");
            sort_drain(v, 2, 1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/comparator_sort_controller.md
Name: comparator_sort_controller

Overview:
- Sequencer that shares one four_bit_comparator instance (internal, unmodified) to bubble-sort a block of N 4-bit values.
- Accepts N values over a valid/ready input stream, runs compare/swap passes one comparison per cycle, then streams the values out in ascending order.
- Sits behind the comparator datapath as its controller; the comparator's G output drives every swap decision.

Parameters:
- N, 4, number of entries per block; legal range 2..8.
- IDXW, 3, index width; must satisfy 2^IDXW >= N; no derivation required.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input beat valid
- in_data  input  4  unsigned input value
- in_ready  output  1  controller can accept a beat
- out_valid  output  1  sorted beat valid
- out_data  output  4  sorted value
- out_ready  input  1  consumer accepts the beat
- busy  output  1  high in SORT_CMP/SORT_SWAP
- sort_done  output  1  one-cycle pulse on entry to DRAIN
- swap_cnt  output  8  number of swaps in the last/current sort

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n. rst_n sampled low at an edge:
  - state=LOAD; all indexes and pass counters = 0; swapped flag = 0.
  - in_ready=1 in the first cycle after reset; out_valid=0, busy=0, sort_done=0, swap_cnt=0.
  - Storage array mem[0..N-1] is not reset.
- States: LOAD, SORT_CMP, SORT_SWAP, DRAIN.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: mem[wr_idx]<=in_data and wr_idx increments.
  - Accepting beat N-1: go to SORT_CMP with j=0, pass=0, swapped=0, swap_cnt=0.
- SORT_CMP:
  - Comparator inputs: A=mem[j], B=mem[j+1].
  - If G=1: go to SORT_SWAP.
  - If G=0 (equal or less, no swap, so the sort is stable): advance.
- SORT_SWAP (exactly one cycle):
  - mem[j] and mem[j+1] exchange.
  - swapped<=1; swap_cnt increments, saturating at 255.
  - Then advance.
- Advance rule:
  - If j < N-2-pass: j<=j+1, return to SORT_CMP.
  - Else end of pass. If swapped==0 or pass==N-2: go to DRAIN. Otherwise pass<=pass+1, j<=0, swapped<=0, go to SORT_CMP.
- Cycle cost: 1 cycle per compare + 1 cycle per swap. Worst case for N=4 is 12 cycles.
- DRAIN entry: sort_done is high for exactly the first DRAIN cycle (registered).
- DRAIN:
  - out_valid=1, out_data=mem[rd_idx], rd_idx starts at 0.
  - On out_valid&&out_ready: rd_idx increments.
  - After beat N-1 is accepted: go to LOAD with wr_idx=0 and rd_idx=0. The next cycle has out_valid=0 and in_ready=1.
  - While out_ready=0, out_valid and out_data hold stable.
- in_ready=0 outside LOAD; in_valid is ignored there. out_ready is ignored outside DRAIN.
- busy=1 only in SORT_CMP/SORT_SWAP.
- swap_cnt holds its value through DRAIN and the next LOAD, until the next sort starts.
- Reset mid-operation (any state) aborts the block. Partial data is discarded and no output beat is produced.
- The comparator's E and L outputs are unused. Only G affects control.

Test Plan:
- Load 15,9,4,0 with out_ready=1 -> busy high exactly 12 cycles; sort_done one pulse; outputs 0,4,9,15 on 4 consecutive cycles; swap_cnt=6.
- Load 1,2,3,4 -> early exit after 3 SORT_CMP cycles; swap_cnt=0; outputs 1,2,3,4.
- Load 7,7,3,7 -> busy 8 cycles (6 compares, 2 swaps); outputs 3,7,7,7; swap_cnt=2.
- Load 5,0xA,2,8 and toggle out_ready 1,0,0,1,… in DRAIN:
  - out_data holds while stalled; sequence 2,5,8,0xA.
  - After the last beat, in_ready=1 and out_valid=0.
  - Interleave in_valid beats during SORT/DRAIN -> all ignored (in_ready=0).
- Drop rst_n for one cycle in mid-sort (after 3 busy cycles) -> next cycle state LOAD, busy=0, out_valid=0, swap_cnt=0. A fresh load of 3,1,2,0 then yields 0,1,2,3.
- Back-to-back blocks: a second block of 4 beats offered immediately after the first drain -> accepted starting the cycle after the last out beat; both blocks sorted correctly.
